// File: rtl/eth_rx_payload_buf.sv
// eth_rx_payload_buf: Ethernet RX header filter feeding a frame-atomic payload FIFO
module eth_rx_payload_buf #(
  parameter int          P_DEPTH     = 2048,
  parameter logic [47:0] P_MAC       = 48'h02_00_00_00_00_01,
  parameter logic [15:0] P_ETHERTYPE = 16'h88B5,
  parameter int          P_CNT_W     = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [7:0]         i_mac_data,
  input  logic               i_mac_valid,
  input  logic               i_mac_sof,
  input  logic               i_mac_eof,
  input  logic               i_mac_err,
  input  logic               i_rreq,
  output logic [7:0]         o_rdata,
  output logic               o_rready,
  output logic [P_CNT_W-1:0] o_frames_ok,
  output logic [P_CNT_W-1:0] o_frames_drop
);
  localparam int AW = $clog2(P_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(P_DEPTH);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DISCARD} state_t;
  state_t state_q, state_d;
  logic [3:0] hdr_cnt_q, hdr_cnt_d;
  logic [47:0] da_q, da_d;
  logic [7:0] type_hi_q, type_hi_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0] rdata_q;
  logic rready_q;
  logic [P_CNT_W-1:0] ok_q, drop_q;
  logic ok_inc, drop_inc, wr_en, rd_en, filt_pass, full;
  logic [7:0] mem [P_DEPTH];
  assign full = (wr_ptr_q - rd_ptr_q) == DEPTH;
  assign filt_pass = (da_q == P_MAC || da_q == '1) && {type_hi_q, i_mac_data} == P_ETHERTYPE;
  assign rd_en = i_rreq && rready_q;
  assign rd_ptr_d = rd_ptr_q + rd_en;
  assign o_rdata = rdata_q;
  assign o_rready = rready_q;
  assign o_frames_ok = ok_q;
  assign o_frames_drop = drop_q;
  // RX parser: header capture, filtering, speculative writes, commit/rollback, drop accounting
  always_comb begin
    state_d = state_q;
    hdr_cnt_d = hdr_cnt_q;
    da_d = da_q;
    type_hi_d = type_hi_q;
    wr_ptr_d = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    ok_inc = 1'b0;
    drop_inc = 1'b0;
    wr_en = 1'b0;
    if (i_mac_valid) begin
      if (i_mac_sof) begin
        drop_inc = state_q == HDR || state_q == PAYLOAD || i_mac_eof;
        if (state_q == PAYLOAD) wr_ptr_d = commit_ptr_q;
        da_d = {da_q[39:0], i_mac_data};
        hdr_cnt_d = 4'd1;
        state_d = i_mac_eof ? IDLE : HDR;
      end else begin
        case (state_q)
          HDR: begin
            hdr_cnt_d = hdr_cnt_q + 4'd1;
            if (hdr_cnt_q < 4'd6) da_d = {da_q[39:0], i_mac_data};
            if (hdr_cnt_q == 4'd12) type_hi_d = i_mac_data;
            if (hdr_cnt_q == 4'd13) begin
              ok_inc = filt_pass && i_mac_eof && !i_mac_err;
              drop_inc = !filt_pass || (i_mac_eof && i_mac_err);
              state_d = i_mac_eof ? IDLE : filt_pass ? PAYLOAD : DISCARD;
            end else if (i_mac_eof) begin
              drop_inc = 1'b1;
              state_d = IDLE;
            end
          end
          PAYLOAD: begin
            if (full) begin
              wr_ptr_d = commit_ptr_q;
              drop_inc = 1'b1;
              state_d = i_mac_eof ? IDLE : DISCARD;
            end else begin
              wr_en = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              if (i_mac_eof) begin
                state_d = IDLE;
                ok_inc = !i_mac_err;
                drop_inc = i_mac_err;
                wr_ptr_d = i_mac_err ? commit_ptr_q : wr_ptr_q + 1'b1;
                commit_ptr_d = i_mac_err ? commit_ptr_q : wr_ptr_q + 1'b1;
              end
            end
          end
          DISCARD: state_d = i_mac_eof ? IDLE : DISCARD;
          default: ;
        endcase
      end
    end
  end
  // Parser, pointer, pop-side and statistics registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      hdr_cnt_q <= '0;
      da_q <= '0;
      type_hi_q <= '0;
      wr_ptr_q <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q <= '0;
      rready_q <= 1'b0;
      ok_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      da_q <= da_d;
      type_hi_q <= type_hi_d;
      wr_ptr_q <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rready_q <= commit_ptr_d != rd_ptr_d;
      if (rd_en) rdata_q <= mem[rd_ptr_q[AW-1:0]];
      if (ok_inc && !(&ok_q)) ok_q <= ok_q + 1'b1;
      if (drop_inc && !(&drop_q)) drop_q <= drop_q + 1'b1;
    end
  end
  // Payload storage, written at the speculative pointer
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= i_mac_data;
  end
endmodule

// File: tb/tb_eth_rx_payload_buf.sv
// tb_eth_rx_payload_buf: scoreboard bench for the RX payload buffer
module tb_eth_rx_payload_buf;
  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] mac_data = '0;
  logic mac_valid = 1'b0, sof = 1'b0, eof = 1'b0, err = 1'b0, rreq = 1'b0;
  logic [7:0] rdata;
  logic rready;
  logic [15:0] fok, fdrop;
  logic [7:0] exp_q[$];
  int passes = 0, checks = 0;
  bit pop_pend = 1'b0;
  always #5 clk = ~clk;
  eth_rx_payload_buf #(.P_DEPTH(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mac_data(mac_data), .i_mac_valid(mac_valid),
    .i_mac_sof(sof), .i_mac_eof(eof), .i_mac_err(err), .i_rreq(rreq),
    .o_rdata(rdata), .o_rready(rready), .o_frames_ok(fok), .o_frames_drop(fdrop)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask
  // Monitor: a pop accepted at one edge is compared against the scoreboard at the next negedge
  always @(negedge clk) begin
    if (!rst_n) pop_pend = 1'b0;
    else begin
      if (pop_pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL pop_unexpected: got %0h want no data", rdata);
        end else chk("rdata", rdata, exp_q.pop_front());
      end
      pop_pend = rreq && rready;
    end
  end
  function automatic bq_t mk(input logic [47:0] da, input logic [15:0] et, input int n,
                             input logic [7:0] base, input logic [7:0] step);
    bq_t f;
    logic [7:0] v;
    for (int i = 0; i < 6; i++) f.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(8'h10 + 8'(i));
    f.push_back(et[15:8]);
    f.push_back(et[7:0]);
    v = base;
    for (int i = 0; i < n; i++) begin
      f.push_back(v);
      v = v + step;
    end
    return f;
  endfunction
  task automatic expect_pl(input int n, input logic [7:0] base, input logic [7:0] step);
    logic [7:0] v;
    v = base;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      v = v + step;
    end
  endtask
  task automatic send(input bq_t f, input bit e, input bit use_sof, input bit use_eof);
    foreach (f[i]) begin
      @(posedge clk); #1;
      mac_valid = 1'b1;
      mac_data = f[i];
      sof = use_sof && i == 0;
      eof = use_eof && i == f.size() - 1;
      err = e && eof;
    end
    @(posedge clk); #1;
    mac_valid = 1'b0; sof = 1'b0; eof = 1'b0; err = 1'b0;
  endtask
  task automatic pop_n(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rreq = 1'b1;
    end
    @(posedge clk); #1;
    rreq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    bq_t f;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rready", rready, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ok", fok, 0);
    chk("rst_drop", fdrop, 0);
    rst_n = 1'b1;
    send(mk(MAC, 16'h88B5, 10, 8'h01, 8'h01), 0, 1, 1);
    chk("t1_rready_eof1", rready, 1);
    expect_pl(10, 8'h01, 8'h01);
    pop_n(12);
    chk("t1_rready_low", rready, 0);
    chk("t1_rdata_hold", rdata, 8'h0A);
    chk("t1_ok", fok, 1);
    chk("t1_drop", fdrop, 0);
    send(mk(MAC, 16'h0800, 2, 8'h11, 8'h11), 0, 1, 1);
    chk("t2_filtered_rready", rready, 0);
    send(mk(BCAST, 16'h88B5, 2, 8'hAA, 8'h11), 0, 1, 1);
    expect_pl(2, 8'hAA, 8'h11);
    pop_n(3);
    chk("t2_ok", fok, 2);
    chk("t2_drop", fdrop, 1);
    send(mk(MAC, 16'h88B5, 20, 8'h01, 8'h01), 1, 1, 1);
    chk("t3_err_rready", rready, 0);
    chk("t3_drop", fdrop, 2);
    send(mk(MAC, 16'h88B5, 3, 8'hC1, 8'h01), 0, 1, 1);
    expect_pl(3, 8'hC1, 8'h01);
    pop_n(5);
    chk("t3_rdata_last", rdata, 8'hC3);
    chk("t3_ok", fok, 3);
    send(mk(MAC, 16'h88B5, 40, 8'h40, 8'h01), 0, 1, 1);
    expect_pl(40, 8'h40, 8'h01);
    send(mk(MAC, 16'h88B5, 30, 8'h80, 8'h01), 0, 1, 1);
    chk("t4_drop", fdrop, 3);
    chk("t4_ok", fok, 4);
    pop_n(42);
    chk("t4_rready_low", rready, 0);
    send(mk(MAC, 16'h88B5, 5, 8'h90, 8'h01), 0, 1, 0);
    send(mk(MAC, 16'h88B5, 4, 8'hD1, 8'h01), 0, 1, 1);
    expect_pl(4, 8'hD1, 8'h01);
    chk("t5_drop", fdrop, 4);
    chk("t5_ok", fok, 5);
    pop_n(6);
    chk("t5_rdata_hold", rdata, 8'hD4);
    chk("t5_rready_low", rready, 0);
    send(mk(MAC, 16'h88B5, 2, 8'hE1, 8'h01), 0, 1, 1);
    expect_pl(2, 8'hE1, 8'h01);
    pop_n(2);
    chk("t5_rdata_after", rdata, 8'hE2);
    chk("t5_ok2", fok, 6);
    f = mk(MAC, 16'h88B5, 0, 8'h00, 8'h00);
    f = f[0:9];
    send(f, 0, 1, 1);
    chk("runt_drop", fdrop, 5);
    send(mk(MAC, 16'h88B5, 0, 8'h00, 8'h00), 0, 1, 1);
    chk("zero_pl_ok", fok, 7);
    chk("zero_pl_rready", rready, 0);
    send(mk(MAC, 16'h88B5, 8, 8'hF0, 8'h01), 0, 1, 1);
    chk("t6_committed", rready, 1);
    send(mk(MAC, 16'h88B5, 6, 8'h60, 8'h01), 0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rready", rready, 0);
    chk("t6_rst_rdata", rdata, 0);
    chk("t6_rst_ok", fok, 0);
    chk("t6_rst_drop", fdrop, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(mk(MAC, 16'h88B5, 3, 8'h31, 8'h01), 0, 0, 1);
    chk("t6_nosof_rready", rready, 0);
    chk("t6_nosof_ok", fok, 0);
    chk("t6_nosof_drop", fdrop, 0);
    send(mk(MAC, 16'h88B5, 3, 8'h31, 8'h01), 0, 1, 1);
    expect_pl(3, 8'h31, 8'h01);
    chk("t6_ok", fok, 1);
    pop_n(3);
    chk("t6_rready_low", rready, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
